// File: rtl/gsm_at_cmd_tx.sv
// gsm_at_cmd_tx: turns dial / hang-up pulses into AT command strings
// ("ATD<11 digits>;\r\n" or "ATH\r\n") and streams them byte by byte to
// a UART TX through a tx_start / tx_done handshake.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   key_flag1, key_flag2  dial / hang-up request pulses
//   telephone[87:0]       11 ASCII digits, first digit in [87:80]
//   tx_done               UART byte-finished pulse
//   tx_data, tx_start     byte and one-cycle start request to the UART
//   busy                  command in progress
//   cmd_done, cmd_err     completion / timeout-abort pulses
module gsm_at_cmd_tx #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int CNT_W          = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_flag1,
  input  logic        key_flag2,
  input  logic [87:0] telephone,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP
  } state_t;

  // GAP lasts at least one cycle even when no gap is requested
  localparam logic [CNT_W-1:0] L_GAP_END =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] L_TO_END =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_n;
  logic             r_pend_dial;
  logic             r_pend_hang;
  logic             r_is_dial;
  logic [87:0]      r_num;
  logic [4:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic             w_is_dial_n;
  logic [4:0]       w_idx_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [7:0]       w_tx_data_n;
  logic             w_tx_start_n;
  logic             w_busy_n;
  logic             w_done_n;
  logic             w_err_n;
  logic             w_clr_dial;
  logic             w_clr_hang;
  logic             w_num_lock;
  logic [4:0]       w_last;
  logic [3:0]       w_dsel;
  logic [7:0]       w_digit;
  logic [7:0]       w_byte;

  assign w_last     = r_is_dial ? 5'd16 : 5'd4;
  // number is frozen while a dial string is on the wire
  assign w_num_lock = (r_state != S_IDLE) && r_is_dial;

  // digit k (index 3..13) lives at bit 8*(13-index)
  always_comb begin
    w_dsel = 4'd0;
    if (r_idx >= 5'd3 && r_idx <= 5'd13) begin
      w_dsel = 4'(5'd13 - r_idx);
    end
    w_digit = 8'(r_num >> {w_dsel, 3'b000});
  end

  always_comb begin
    w_byte = 8'h00;
    if (r_is_dial) begin
      case (r_idx)
        5'd0:    w_byte = 8'h41;
        5'd1:    w_byte = 8'h54;
        5'd2:    w_byte = 8'h44;
        5'd14:   w_byte = 8'h3B;
        5'd15:   w_byte = 8'h0D;
        5'd16:   w_byte = 8'h0A;
        default: w_byte = w_digit;
      endcase
    end else begin
      case (r_idx)
        5'd0:    w_byte = 8'h41;
        5'd1:    w_byte = 8'h54;
        5'd2:    w_byte = 8'h48;
        5'd3:    w_byte = 8'h0D;
        5'd4:    w_byte = 8'h0A;
        default: w_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_is_dial_n  = r_is_dial;
    w_idx_n      = r_idx;
    w_cnt_n      = r_cnt;
    w_tx_data_n  = tx_data;
    w_tx_start_n = 1'b0;
    w_busy_n     = busy;
    w_done_n     = 1'b0;
    w_err_n      = 1'b0;
    w_clr_dial   = 1'b0;
    w_clr_hang   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend_hang) begin
          w_state_n   = S_LOAD;
          w_is_dial_n = 1'b0;
          w_idx_n     = 5'd0;
          w_busy_n    = 1'b1;
          w_clr_hang  = 1'b1;
        end else if (r_pend_dial) begin
          w_state_n   = S_LOAD;
          w_is_dial_n = 1'b1;
          w_idx_n     = 5'd0;
          w_busy_n    = 1'b1;
          w_clr_dial  = 1'b1;
        end
      end
      S_LOAD: begin
        w_tx_data_n  = w_byte;
        w_tx_start_n = 1'b1;
        w_cnt_n      = '0;
        w_state_n    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          w_cnt_n = '0;
          if (r_idx == w_last) begin
            w_state_n = S_IDLE;
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
          end else begin
            w_state_n = S_GAP;
          end
        end else if (r_cnt == L_TO_END) begin
          w_state_n = S_IDLE;
          w_err_n   = 1'b1;
          w_busy_n  = 1'b0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt >= L_GAP_END) begin
          w_idx_n   = r_idx + 5'd1;
          w_state_n = S_LOAD;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_is_dial   <= 1'b0;
      r_idx       <= 5'd0;
      r_cnt       <= '0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_is_dial   <= w_is_dial_n;
      r_idx       <= w_idx_n;
      r_cnt       <= w_cnt_n;
      tx_data     <= w_tx_data_n;
      tx_start    <= w_tx_start_n;
      busy        <= w_busy_n;
      cmd_done    <= w_done_n;
      cmd_err     <= w_err_n;
    end
  end

  // a new pulse in the cycle its flag is consumed stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_dial <= 1'b0;
      r_pend_hang <= 1'b0;
      r_num       <= '0;
    end else begin
      r_pend_dial <= key_flag1 | (r_pend_dial & ~w_clr_dial);
      r_pend_hang <= key_flag2 | (r_pend_hang & ~w_clr_hang);
      if (key_flag1 && !w_num_lock) begin
        r_num <= telephone;
      end
    end
  end

endmodule

// File: tb/tb_gsm_at_cmd_tx.sv
// tb_gsm_at_cmd_tx: randomized bench for gsm_at_cmd_tx, checking the
// transmitted bytes against strings built from the command rules.
module tb_gsm_at_cmd_tx;

  localparam int GAP = 2;
  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_flag1 = 1'b0;
  logic        key_flag2 = 1'b0;
  logic [87:0] telephone = '0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic        cmd_done;
  logic        cmd_err;

  always #5 clk = ~clk;

  gsm_at_cmd_tx #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (24)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_flag1(key_flag1),
    .key_flag2(key_flag2),
    .telephone(telephone),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .busy     (busy),
    .cmd_done (cmd_done),
    .cmd_err  (cmd_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_done = 0;
  int n_err = 0;
  int exp_start = 0;
  int exp_done = 0;
  int exp_err = 0;

  logic [7:0] exp_b[$];
  bit         exp_last[$];

  always @(negedge clk) begin
    if (tx_start) n_start <= n_start + 1;
    if (cmd_done) n_done <= n_done + 1;
    if (cmd_err)  n_err <= n_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [87:0] rand_num();
    logic [87:0] n;
    n = '0;
    for (int i = 0; i < 11; i++) begin
      n[8*(10-i) +: 8] = 8'h30 + 8'($urandom_range(9));
    end
    return n;
  endfunction

  task automatic push(input logic [7:0] b, input bit last);
    exp_b.push_back(b);
    exp_last.push_back(last);
  endtask

  task automatic push_dial(input logic [87:0] num);
    push(8'h41, 0);
    push(8'h54, 0);
    push(8'h44, 0);
    for (int i = 0; i < 11; i++) push(num[8*(10-i) +: 8], 0);
    push(8'h3B, 0);
    push(8'h0D, 0);
    push(8'h0A, 1);
  endtask

  task automatic push_hang();
    push(8'h41, 0);
    push(8'h54, 0);
    push(8'h48, 0);
    push(8'h0D, 0);
    push(8'h0A, 1);
  endtask

  task automatic pulse(input bit k1, input bit k2);
    key_flag1 = k1;
    key_flag2 = k2;
    @(negedge clk);
    key_flag1 = 1'b0;
    key_flag2 = 1'b0;
  endtask

  task automatic wait_start(output int w);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!tx_start && w < 300);
    check("tx_start seen", {31'd0, tx_start}, 1);
  endtask

  // Answers every byte in the expected queue; side actions fire at the
  // tx_start of the byte whose running index matches.
  task automatic serve(input int hang_at, input int tel_at,
                       input int hold_at, input int rst_at,
                       input logic [87:0] new_tel);
    int w;
    int c;
    int i;
    bit first;
    bit prev_last;
    logic [7:0] b;
    bit last;
    i = 0;
    first = 1;
    prev_last = 0;
    while (exp_b.size() > 0) begin
      b = exp_b.pop_front();
      last = exp_last.pop_front();
      wait_start(w);
      if (!tx_start) begin
        exp_b.delete();
        exp_last.delete();
        break;
      end
      if (first) check("start latency", w, 2);
      else if (!prev_last) check("gap window", {31'd0, w >= GAP && w <= GAP + 3}, 1);
      check("tx_data", {24'd0, tx_data}, {24'd0, b});
      exp_start++;
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 check("async reset outputs",
                 {20'd0, tx_data, tx_start, busy, cmd_done, cmd_err}, 0);
        exp_b.delete();
        exp_last.delete();
        break;
      end
      if (i == hang_at) key_flag2 = 1'b1;
      if (i == tel_at) telephone = new_tel;
      if (i == hold_at) begin
        c = 0;
        do begin
          @(negedge clk);
          key_flag2 = 1'b0;
          c++;
        end while (!cmd_err && c < 2 * TMO);
        check("timeout cycle", c, TMO);
        check("busy after err", {31'd0, busy}, 0);
        exp_err++;
        exp_b.delete();
        exp_last.delete();
        break;
      end
      @(negedge clk);
      key_flag2 = 1'b0;
      check("start one cycle", {31'd0, tx_start}, 0);
      check("tx_data hold", {24'd0, tx_data}, {24'd0, b});
      repeat ($urandom_range(3)) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("cmd_done", {31'd0, cmd_done}, {31'd0, last});
      if (last) begin
        check("busy after done", {31'd0, busy}, 0);
        exp_done++;
      end
      first = 0;
      prev_last = last;
      i++;
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    check("idle busy", {31'd0, busy}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [87:0] num_a;
    logic [87:0] num_b;
    logic [87:0] n;
    int kind;

    num_a = 88'h3138_3233_3732_3939_3437_35;
    num_b = 88'h3138_3734_3034_3034_3339_39;

    repeat (3) @(negedge clk);
    check("reset outputs",
          {20'd0, tx_data, tx_start, busy, cmd_done, cmd_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    telephone = num_a;
    push_dial(num_a);
    pulse(1, 0);
    serve(-1, -1, -1, -1, '0);
    settle();

    push_hang();
    pulse(0, 1);
    serve(-1, -1, -1, -1, '0);
    settle();

    telephone = num_b;
    push_dial(num_b);
    pulse(1, 0);
    serve(-1, 4, -1, -1, num_a);
    settle();

    push_dial(num_a);
    push_hang();
    pulse(1, 0);
    serve(8, -1, -1, -1, '0);
    settle();

    push_hang();
    push_dial(num_a);
    pulse(1, 1);
    serve(-1, -1, -1, -1, '0);
    settle();

    push_dial(num_a);
    pulse(1, 0);
    serve(-1, -1, 3, -1, '0);
    settle();
    push_dial(num_a);
    pulse(1, 0);
    serve(-1, -1, -1, -1, '0);
    settle();

    push_dial(num_a);
    pulse(1, 0);
    serve(2, -1, -1, 9, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("pending lost after reset", {31'd0, busy}, 0);

    for (int it = 0; it < 16; it++) begin
      kind = $urandom_range(4);
      n = rand_num();
      telephone = n;
      case (kind)
        0: begin
          push_dial(n);
          pulse(1, 0);
          serve(-1, -1, -1, -1, '0);
        end
        1: begin
          push_hang();
          pulse(0, 1);
          serve(-1, -1, -1, -1, '0);
        end
        2: begin
          push_hang();
          push_dial(n);
          pulse(1, 1);
          serve(-1, -1, -1, -1, '0);
        end
        3: begin
          push_dial(n);
          push_hang();
          pulse(1, 0);
          serve($urandom_range(16), -1, -1, -1, '0);
        end
        default: begin
          push_dial(n);
          pulse(1, 0);
          serve(-1, $urandom_range(16), -1, -1, rand_num());
        end
      endcase
      settle();
    end

    repeat (5) @(negedge clk);
    check("tx_start count", n_start, exp_start);
    check("cmd_done count", n_done, exp_done);
    check("cmd_err count", n_err, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
